// File: rtl/riva_pkg.sv
// Shared types for the MLSU tile pre-decoder.
// mop_e names the walk encodings carried on req_mop_i. mlsu_tile_entry_t is
// the entry layout at the default widths; the top module rebuilds the same
// layout at its own parameter widths.
package riva_pkg;

  localparam int unsigned ADDR_W_DEF = 64;
  localparam int unsigned TILE_W_DEF = 8;
  localparam int unsigned ID_W_DEF   = 4;

  typedef enum logic [1:0] {
    MOP_ROW  = 2'd0,
    MOP_COL  = 2'd1,
    MOP_RCOL = 2'd2,
    MOP_ILL  = 2'd3
  } mop_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_EXPAND = 1'b1
  } predec_state_e;

  typedef struct packed {
    logic [ID_W_DEF-1:0]   id;
    logic [ADDR_W_DEF-1:0] addr;
    logic [TILE_W_DEF-1:0] tile_idx;
    logic                  last;
    logic [2:0]            mode;
    logic [1:0]            sew;
    logic                  is_load;
  } mlsu_tile_entry_t;

  // One-hot walk mode reported downstream (1 << mop).
  function automatic logic [2:0] mop_onehot(input mop_e mop);
    logic [2:0] oh;
    oh = 3'b000;
    oh[mop] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/mlsu_predec_fifo.sv
// Generic registered FIFO (no fall-through). An entry pushed in cycle N is
// visible on data_o in cycle N+1. flush_i empties the FIFO next cycle and
// blocks any push in the flush cycle.
module mlsu_predec_fifo #(
  parameter type         T     = logic [7:0],
  parameter int unsigned DEPTH = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic flush_i,
  input  logic push_i,
  input  T     data_i,
  input  logic pop_i,
  output T     data_o,
  output logic full_o,
  output logic empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  T                 mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign data_o  = mem_q[rd_ptr_q];

  // A push into a full FIFO is only taken when a pop frees a slot this cycle.
  assign do_push = push_i && !flush_i && (!full_o || pop_i);
  assign do_pop  = pop_i && !empty_o;

  // Entry storage.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (do_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  // Read/write pointers and occupancy.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/mlsu_tile_predecoder.sv
// MLSU tile request pre-decoder: captures one matrix load/store request and
// expands it into one entry per tile row/column (row, column, reverse column
// walks), buffered in a registered output FIFO.
// Optional build macro MLSU_PREDEC_PERF_EN adds perf_entries_o/perf_stall_o.
//
// Handshakes: both ports are valid/ready; a transfer happens on a rising
// clock edge where valid and ready are both high. Payload must be held while
// valid is high and ready is low, and predec_* are held stable likewise.
module mlsu_tile_predecoder
  import riva_pkg::*;
#(
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned TILE_W     = TILE_W_DEF,
  parameter int unsigned ID_W       = ID_W_DEF,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned ADDR_SHIFT = 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [ID_W-1:0]   req_id_i,
  input  logic [ADDR_W-1:0] req_base_addr_i,
  input  logic [ADDR_W-1:0] req_stride_i,
  input  logic [TILE_W-1:0] req_tile_i,
  input  logic [1:0]        req_mop_i,
  input  logic [1:0]        req_sew_i,
  input  logic              req_is_load_i,
  output logic              predec_valid_o,
  input  logic              predec_ready_i,
  output logic [ID_W-1:0]   predec_id_o,
  output logic [ADDR_W-1:0] predec_addr_o,
  output logic [TILE_W-1:0] predec_tile_idx_o,
  output logic              predec_last_o,
  output logic [2:0]        predec_mode_o,
  output logic [1:0]        predec_sew_o,
  output logic              predec_is_load_o,
  output logic              err_o,
  output logic              busy_o
`ifdef MLSU_PREDEC_PERF_EN
  ,
  output logic [31:0]       perf_entries_o,
  output logic [31:0]       perf_stall_o
`endif
);

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [ADDR_W-1:0] addr;
    logic [TILE_W-1:0] tile_idx;
    logic              last;
    logic [2:0]        mode;
    logic [1:0]        sew;
    logic              is_load;
  } entry_t;

  predec_state_e     state_q, state_d;
  logic [ID_W-1:0]   id_q;
  mop_e              mop_q;
  logic [1:0]        sew_q;
  logic              is_load_q;
  logic [ADDR_W-1:0] stride_q, addr_q, addr_next;
  logic [TILE_W-1:0] cnt_q, idx_q;
  logic              err_q;

  logic   enq_valid, enq_ready, enq_fire, accept, req_legal, cnt_last;
  logic   fifo_full, fifo_empty, deq_fire;
  entry_t enq_entry, deq_entry;

  assign cnt_last  = (cnt_q == TILE_W'(1));
  assign req_legal = (mop_e'(req_mop_i) != MOP_ILL) && (req_tile_i != '0);
  assign accept    = req_valid_i && req_ready_o;
  assign enq_ready = !fifo_full || predec_ready_i;
  assign enq_fire  = enq_valid && enq_ready;
  assign deq_fire  = !fifo_empty && predec_ready_i;

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // FSM next state: flush wins; the final enqueue may chain straight into a new request.
  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:   if (accept && req_legal) state_d = ST_EXPAND;
        ST_EXPAND: if (enq_fire && cnt_last) state_d = (accept && req_legal) ? ST_EXPAND : ST_IDLE;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  // FSM outputs: request ready and enqueue attempt.
  always_comb begin
    req_ready_o = 1'b0;
    enq_valid   = 1'b0;
    if (!flush_i) begin
      case (state_q)
        ST_IDLE:   req_ready_o = 1'b1;
        ST_EXPAND: begin
          enq_valid   = 1'b1;
          req_ready_o = cnt_last && enq_ready;
        end
        default: ;
      endcase
    end
  end

  // Address of the following entry, modulo 2^ADDR_W.
  always_comb begin
    case (mop_q)
      MOP_ROW:  addr_next = addr_q + (ADDR_W'(1) << sew_q);
      MOP_COL:  addr_next = addr_q + stride_q;
      MOP_RCOL: addr_next = addr_q - stride_q;
      default:  addr_next = addr_q;
    endcase
  end

  // Request capture and per-entry walk registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      id_q      <= '0;
      mop_q     <= MOP_ROW;
      sew_q     <= '0;
      is_load_q <= 1'b0;
      stride_q  <= '0;
      addr_q    <= '0;
      cnt_q     <= '0;
      idx_q     <= '0;
    end else if (flush_i) begin
      cnt_q <= '0;
    end else if (accept && req_legal) begin
      id_q      <= req_id_i;
      mop_q     <= mop_e'(req_mop_i);
      sew_q     <= req_sew_i;
      is_load_q <= req_is_load_i;
      stride_q  <= req_stride_i;
      addr_q    <= req_base_addr_i << ADDR_SHIFT;
      cnt_q     <= req_tile_i;
      idx_q     <= '0;
    end else if (enq_fire) begin
      cnt_q  <= cnt_q - 1'b1;
      idx_q  <= idx_q + 1'b1;
      addr_q <= addr_next;
    end
  end

  // Error pulse the cycle after an illegal request is accepted.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) err_q <= 1'b0;
    else         err_q <= accept && !req_legal;
  end

  // Entry assembled from the walk registers.
  always_comb begin
    enq_entry          = '0;
    enq_entry.id       = id_q;
    enq_entry.addr     = addr_q;
    enq_entry.tile_idx = idx_q;
    enq_entry.last     = cnt_last;
    enq_entry.mode     = mop_onehot(mop_q);
    enq_entry.sew      = sew_q;
    enq_entry.is_load  = is_load_q;
  end

  mlsu_predec_fifo #(
    .T     (entry_t),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (flush_i),
    .push_i  (enq_fire),
    .data_i  (enq_entry),
    .pop_i   (predec_ready_i),
    .data_o  (deq_entry),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign predec_valid_o    = !fifo_empty;
  assign predec_id_o       = deq_entry.id;
  assign predec_addr_o     = deq_entry.addr;
  assign predec_tile_idx_o = deq_entry.tile_idx;
  assign predec_last_o     = deq_entry.last;
  assign predec_mode_o     = deq_entry.mode;
  assign predec_sew_o      = deq_entry.sew;
  assign predec_is_load_o  = deq_entry.is_load;
  assign err_o             = err_q;
  assign busy_o            = (state_q != ST_IDLE) || !fifo_empty;

`ifdef MLSU_PREDEC_PERF_EN
  logic [31:0] perf_entries_q, perf_stall_q;

  // Saturating counters of dequeued entries and full-FIFO expansion cycles; reset only.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_entries_q <= '0;
      perf_stall_q   <= '0;
    end else begin
      if (deq_fire && (perf_entries_q != '1)) perf_entries_q <= perf_entries_q + 1'b1;
      if ((state_q == ST_EXPAND) && fifo_full && (perf_stall_q != '1))
        perf_stall_q <= perf_stall_q + 1'b1;
    end
  end

  assign perf_entries_o = perf_entries_q;
  assign perf_stall_o   = perf_stall_q;
`else
  logic unused_deq_fire;
  assign unused_deq_fire = deq_fire;
`endif

endmodule

// File: tb/tb_mlsu_tile_predecoder.sv
// Bench for mlsu_tile_predecoder: reset checks, a table of single-request
// walks, hand-written multi-cycle sequences (backpressure, back-to-back,
// flush, errors, maximum tile) and a randomized phase checked by a scoreboard
// whose expected entries come from closed-form address arithmetic.
module tb_mlsu_tile_predecoder;

  localparam int ADDR_W     = 64;
  localparam int TILE_W     = 8;
  localparam int ID_W       = 4;
  localparam int DEPTH      = 4;
  localparam int ADDR_SHIFT = 1;
  localparam int EW         = ID_W + ADDR_W + TILE_W + 1 + 3 + 2 + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              flush = 1'b0;
  logic              req_valid = 1'b0;
  logic [ID_W-1:0]   req_id = '0;
  logic [ADDR_W-1:0] req_base = '0;
  logic [ADDR_W-1:0] req_stride = '0;
  logic [TILE_W-1:0] req_tile = '0;
  logic [1:0]        req_mop = '0;
  logic [1:0]        req_sew = '0;
  logic              req_ld = 1'b0;
  logic              predec_ready = 1'b1;

  logic              req_ready_o, predec_valid_o, predec_last_o, predec_is_load_o;
  logic              err_o, busy_o;
  logic [ID_W-1:0]   predec_id_o;
  logic [ADDR_W-1:0] predec_addr_o;
  logic [TILE_W-1:0] predec_tile_idx_o;
  logic [2:0]        predec_mode_o;
  logic [1:0]        predec_sew_o;
`ifdef MLSU_PREDEC_PERF_EN
  logic [31:0]       perf_entries_o, perf_stall_o;
`endif

  mlsu_tile_predecoder #(
    .ADDR_W(ADDR_W), .TILE_W(TILE_W), .ID_W(ID_W), .DEPTH(DEPTH), .ADDR_SHIFT(ADDR_SHIFT)
  ) dut (
    .clk_i             (clk),
    .rst_ni            (rst_n),
    .flush_i           (flush),
    .req_valid_i       (req_valid),
    .req_ready_o       (req_ready_o),
    .req_id_i          (req_id),
    .req_base_addr_i   (req_base),
    .req_stride_i      (req_stride),
    .req_tile_i        (req_tile),
    .req_mop_i         (req_mop),
    .req_sew_i         (req_sew),
    .req_is_load_i     (req_ld),
    .predec_valid_o    (predec_valid_o),
    .predec_ready_i    (predec_ready),
    .predec_id_o       (predec_id_o),
    .predec_addr_o     (predec_addr_o),
    .predec_tile_idx_o (predec_tile_idx_o),
    .predec_last_o     (predec_last_o),
    .predec_mode_o     (predec_mode_o),
    .predec_sew_o      (predec_sew_o),
    .predec_is_load_o  (predec_is_load_o),
    .err_o             (err_o),
    .busy_o            (busy_o)
`ifdef MLSU_PREDEC_PERF_EN
    ,
    .perf_entries_o    (perf_entries_o),
    .perf_stall_o      (perf_stall_o)
`endif
  );

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int failures = 0;
  int deq_count = 0;
  logic [EW-1:0] exp_q[$];
  logic sb_en = 1'b0;
  logic err_pending = 1'b0;
  logic prev_hold = 1'b0;
  logic [EW-1:0] prev_entry = '0;
  logic rand_done = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [EW-1:0] pack(input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] addr,
                                         input logic [TILE_W-1:0] idx, input logic last,
                                         input logic [2:0] mode, input logic [1:0] sew, input logic ld);
    return {id, addr, idx, last, mode, sew, ld};
  endfunction

  function automatic logic [EW-1:0] dut_entry();
    return pack(predec_id_o, predec_addr_o, predec_tile_idx_o, predec_last_o,
                predec_mode_o, predec_sew_o, predec_is_load_o);
  endfunction

  // Reference model: entry k of a request, from the walk definition.
  task automatic model_request(input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] base,
                               input logic [ADDR_W-1:0] stride, input logic [TILE_W-1:0] tile,
                               input logic [1:0] mop, input logic [1:0] sew, input logic ld);
    logic [ADDR_W-1:0] a0, a, elem;
    logic [2:0] mode;
    a0   = base << ADDR_SHIFT;
    elem = 64'd1 << sew;
    mode = (mop == 2'd0) ? 3'b001 : (mop == 2'd1) ? 3'b010 : 3'b100;
    for (int k = 0; k < int'(tile); k++) begin
      case (mop)
        2'd0:    a = a0 + 64'(k) * elem;
        2'd1:    a = a0 + 64'(k) * stride;
        default: a = a0 - 64'(k) * stride;
      endcase
      exp_q.push_back(pack(id, a, TILE_W'(k), (k == int'(tile) - 1), mode, sew, ld));
    end
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (rst_n && sb_en) begin
      check("sb_err_pulse", err_o, err_pending);
      if (prev_hold) check("sb_hold_stable", {predec_valid_o, dut_entry()}, {1'b1, prev_entry});
      if (predec_valid_o && predec_ready) begin
        deq_count++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_unexpected: got entry 0x%0h expected none", dut_entry());
        end else begin
          check("sb_entry", dut_entry(), exp_q.pop_front());
        end
      end
      prev_hold  = predec_valid_o && !predec_ready && !flush;
      prev_entry = dut_entry();
      if (flush) exp_q.delete();
      err_pending = 1'b0;
      if (req_valid && req_ready_o) begin
        if (req_mop != 2'd3 && req_tile != '0)
          model_request(req_id, req_base, req_stride, req_tile, req_mop, req_sew, req_ld);
        else
          err_pending = 1'b1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at posedge+#1; returns at posedge+#1 of the cycle after acceptance.
  task automatic send_req(input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] base,
                          input logic [ADDR_W-1:0] stride, input logic [TILE_W-1:0] tile,
                          input logic [1:0] mop, input logic [1:0] sew, input logic ld,
                          output int waited);
    req_valid = 1'b1; req_id = id; req_base = base; req_stride = stride;
    req_tile = tile; req_mop = mop; req_sew = sew; req_ld = ld;
    waited = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (req_ready_o) begin
        waited = i;
        break;
      end
    end
    if (waited < 0) begin
      checks++;
      failures++;
      $display("FAIL req_accept_timeout: got no ready expected ready within 300 cycles");
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while (busy_o && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, busy_o, 1'b0);
    @(posedge clk); #1;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    string             name;
    logic [1:0]        mop;
    logic [1:0]        sew;
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] stride;
    logic [TILE_W-1:0] tile;
    logic [ADDR_W-1:0] a0, a1, a2;
    logic [2:0]        mode;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int w, wb;
    logic [ADDR_W-1:0] ea;

    vecs[0] = '{"row",      2'd0, 2'd2, 64'h100, 64'h0, 8'd3,
                64'h200, 64'h204, 64'h208, 3'b001};
    vecs[1] = '{"col",      2'd1, 2'd0, 64'h40, 64'h80, 8'd2,
                64'h80, 64'h100, 64'h0, 3'b010};
    vecs[2] = '{"rcol",     2'd2, 2'd1, 64'h0, 64'h10, 8'd2,
                64'h0, 64'hFFFF_FFFF_FFFF_FFF0, 64'h0, 3'b100};
    vecs[3] = '{"row_trunc", 2'd0, 2'd0, 64'h8000_0000_0000_0001, 64'h0, 8'd2,
                64'h2, 64'h3, 64'h0, 3'b001};
    vecs[4] = '{"col_wrap", 2'd1, 2'd3, 64'h7FFF_FFFF_FFFF_FFF8, 64'h10, 8'd3,
                64'hFFFF_FFFF_FFFF_FFF0, 64'h0, 64'h10, 3'b010};

    // reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_valid", predec_valid_o, 1'b0);
    check("rst_err", err_o, 1'b0);
    check("rst_busy", busy_o, 1'b0);
    check("rst_req_ready", req_ready_o, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    sb_en = 1'b1;
    @(posedge clk); #1;

    // table of single requests: latency 2 and one entry per cycle
    predec_ready = 1'b1;
    for (int v = 0; v < 5; v++) begin
      send_req(4'(v + 1), vecs[v].base, vecs[v].stride, vecs[v].tile,
               vecs[v].mop, vecs[v].sew, v[0], w);
      @(negedge clk);
      check({vecs[v].name, "_gap_valid"}, predec_valid_o, 1'b0);
      for (int k = 0; k < int'(vecs[v].tile); k++) begin
        ea = (k == 0) ? vecs[v].a0 : (k == 1) ? vecs[v].a1 : vecs[v].a2;
        @(negedge clk);
        check({vecs[v].name, "_valid"}, predec_valid_o, 1'b1);
        check({vecs[v].name, "_addr"}, predec_addr_o, ea);
        check({vecs[v].name, "_idx"}, predec_tile_idx_o, TILE_W'(k));
        check({vecs[v].name, "_last"}, predec_last_o, (k == int'(vecs[v].tile) - 1));
        check({vecs[v].name, "_mode"}, predec_mode_o, vecs[v].mode);
      end
      @(negedge clk);
      check({vecs[v].name, "_done_valid"}, predec_valid_o, 1'b0);
      @(posedge clk); #1;
    end

    // backpressure: 8 entries, 4 buffered, then released in order
    predec_ready = 1'b0;
    send_req(4'd5, 64'h1000, 64'h0, 8'd8, 2'd0, 2'd3, 1'b1, w);
    repeat (10) @(negedge clk);
    check("bp_valid", predec_valid_o, 1'b1);
    check("bp_req_ready", req_ready_o, 1'b0);
    check("bp_busy", busy_o, 1'b1);
    check("bp_head_idx", predec_tile_idx_o, 8'd0);
    check("bp_head_addr", predec_addr_o, 64'h2000);
    @(posedge clk); #1;
    predec_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("bp_rel_valid", predec_valid_o, 1'b1);
      check("bp_rel_idx", predec_tile_idx_o, TILE_W'(k));
      check("bp_rel_addr", predec_addr_o, 64'h2000 + 64'(8 * k));
    end
    @(negedge clk);
    check("bp_drained", predec_valid_o, 1'b0);
    @(posedge clk); #1;

    // back-to-back: tile=1 then tile=2, no bubble
    send_req(4'd1, 64'h10, 64'h0, 8'd1, 2'd0, 2'd0, 1'b0, w);
    send_req(4'd2, 64'h20, 64'h4, 8'd2, 2'd1, 2'd0, 1'b1, wb);
    check("b2b_accept_wait", 32'(wb), 32'd0);
    @(negedge clk);
    check("b2b_a", {predec_valid_o, predec_id_o, predec_addr_o, predec_tile_idx_o, predec_last_o},
          {1'b1, 4'd1, 64'h20, 8'd0, 1'b1});
    @(negedge clk);
    check("b2b_b0", {predec_valid_o, predec_id_o, predec_addr_o, predec_tile_idx_o, predec_last_o},
          {1'b1, 4'd2, 64'h40, 8'd0, 1'b0});
    @(negedge clk);
    check("b2b_b1", {predec_valid_o, predec_id_o, predec_addr_o, predec_tile_idx_o, predec_last_o},
          {1'b1, 4'd2, 64'h44, 8'd1, 1'b1});
    @(posedge clk); #1;
    wait_idle("b2b_idle", 20);

    // flush at the third entry of tile=5 with two entries queued
    predec_ready = 1'b0;
    send_req(4'd7, 64'h300, 64'h0, 8'd5, 2'd0, 2'd1, 1'b0, w);
    @(posedge clk); #1;
    @(posedge clk); #1;
    flush = 1'b1;
    @(negedge clk);
    check("fl_queued_valid", predec_valid_o, 1'b1);
    check("fl_req_ready", req_ready_o, 1'b0);
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    check("fl_after_valid", predec_valid_o, 1'b0);
    check("fl_after_busy", busy_o, 1'b0);
    check("fl_after_ready", req_ready_o, 1'b1);
    @(posedge clk); #1;
    predec_ready = 1'b1;

    // illegal mop, then tile==0: one-cycle error, no entries
    send_req(4'd3, 64'h500, 64'h8, 8'd2, 2'd3, 2'd0, 1'b1, w);
    @(negedge clk);
    check("ill_err", err_o, 1'b1);
    check("ill_valid", predec_valid_o, 1'b0);
    @(negedge clk);
    check("ill_err_clear", err_o, 1'b0);
    check("ill_valid2", predec_valid_o, 1'b0);
    @(posedge clk); #1;
    send_req(4'd4, 64'h500, 64'h8, 8'd0, 2'd1, 2'd0, 1'b1, w);
    @(negedge clk);
    check("t0_err", err_o, 1'b1);
    @(negedge clk);
    check("t0_valid", predec_valid_o, 1'b0);
    check("t0_busy", busy_o, 1'b0);
    @(posedge clk); #1;

    // maximum tile count: every entry checked by the scoreboard
    send_req(4'd9, 64'h5, 64'h3, 8'd255, 2'd2, 2'd0, 1'b0, w);
    wait_idle("max_tile_idle", 600);
    check("max_tile_all_seen", 32'(exp_q.size()), 32'd0);

    // randomized phase with random backpressure and occasional flush
    fork
      begin
        for (int r = 0; r < 60; r++) begin
          send_req(4'($urandom_range(0, 15)), {$urandom, $urandom}, {$urandom, $urandom},
                   ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(1, 9)),
                   2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), w);
          repeat ($urandom_range(0, 3)) begin
            @(posedge clk); #1;
          end
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk); #1;
          predec_ready = ($urandom_range(0, 3) != 0);
          flush = ($urandom_range(0, 40) == 0);
        end
        flush = 1'b0;
        predec_ready = 1'b1;
      end
    join
    @(posedge clk); #1;
    wait_idle("rand_idle", 200);
    check("rand_all_seen", 32'(exp_q.size()), 32'd0);

`ifdef MLSU_PREDEC_PERF_EN
    check("perf_entries", perf_entries_o, 32'(deq_count));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mlsu_tile_predecoder.md
Name: mlsu_tile_predecoder

Overview:
Parametrised successor to the single-mode MLSU request pre-decoder. It accepts one matrix load/store request and expands it into one pre-decoded entry per tile row/column. Each entry carries its own address, tile index and last flag.
- Captures the request into internal registers on acceptance, so the upstream port is released before expansion completes.
- Supports row-major, column-major and reverse column-major walks, plus flush.
- Sits between the MLSU request dispatcher and the address generator.

Parameters:
ADDR_W, 64, address/stride width (bits)
TILE_W, 8, tile count width
ID_W, 4, request id width
DEPTH, 4, output FIFO depth (>=2, power of 2)
ADDR_SHIFT, 1, left shift applied to base address at capture

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
flush_i  in  1  synchronous abort of current request and FIFO contents
req_valid_i  in  1  request valid
req_ready_o  out  1  request accepted when valid&ready
req_id_i  in  ID_W  request id
req_base_addr_i  in  ADDR_W  base address
req_stride_i  in  ADDR_W  stride
req_tile_i  in  TILE_W  number of entries to emit
req_mop_i  in  2  0 row, 1 col, 2 reverse col, 3 illegal
req_sew_i  in  2  element width log2 bytes
req_is_load_i  in  1  load/store
predec_valid_o  out  1  entry valid
predec_ready_i  in  1  entry consumed
predec_id_o  out  ID_W  id
predec_addr_o  out  ADDR_W  entry address
predec_tile_idx_o  out  TILE_W  0-based entry index
predec_last_o  out  1  final entry of request
predec_mode_o  out  3  one-hot 1<<mop
predec_sew_o  out  2  sew
predec_is_load_o  out  1  load/store
err_o  out  1  one-cycle pulse on illegal mop or tile==0 acceptance
busy_o  out  1  state!=IDLE or FIFO non-empty

Behaviour:
- Reset: state IDLE, FIFO empty, all internal registers 0.
  - Output values at reset: predec_valid_o=0, err_o=0, busy_o=0, req_ready_o=1.
- States: IDLE, EXPAND.
- IDLE:
  - req_ready_o=1 unless flush_i.
  - On accept with mop<3 and tile>0: capture id, mop, sew, is_load, stride and cnt=tile; set addr=base<<ADDR_SHIFT (truncated to ADDR_W) and idx=0; go to EXPAND.
  - On accept with mop==3 or tile==0: pulse err_o next cycle; no entry emitted; stay IDLE.
- EXPAND:
  - Enqueue is attempted every cycle; each enqueue pushes {addr, idx, last=(cnt==1), captured fields}.
  - On enqueue: cnt--, idx++, and addr advances by mop: 0 -> addr+(1<<sew); 1 -> addr+stride; 2 -> addr-stride. All address arithmetic is modulo 2^ADDR_W.
  - FIFO full: no enqueue; registers hold.
  - req_ready_o = (cnt==1 && enq_ready && !flush_i). If a new request is accepted on that cycle, it is captured and the state stays EXPAND with no bubble. Otherwise go to IDLE.
- FIFO:
  - Registered, no fall-through.
  - An entry enqueued in cycle N is visible on predec_* in cycle N+1.
  - Simultaneous enq/deq when full is allowed only if deq frees a slot in the same cycle (enq_ready = !full || predec_ready_i).
- Latency and throughput:
  - Request accepted in cycle N -> first entry on output in cycle N+2.
  - Sustained 1 entry/cycle without backpressure.
- Flush (priority over all):
  - Next cycle: state IDLE, FIFO empty, cnt=0.
  - During the flush cycle: req_ready_o=0 and no enqueue.
  - A dequeue handshake in the flush cycle still counts as consumed.
- predec_* outputs are held stable while valid && !ready.
- tile=2^TILE_W-1 must emit exactly that many entries; idx never wraps within a request.

Optional Feature:
MLSU_PREDEC_PERF_EN:
- Defined: adds ports perf_entries_o (32) and perf_stall_o (32).
  - perf_entries_o counts dequeued entries.
  - perf_stall_o counts EXPAND cycles with FIFO full.
  - Both are cleared by reset only (not flush) and saturate at 2^32-1.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- riva_pkg: mop encoding enum (MOP_ROW, MOP_COL, MOP_RCOL, MOP_ILL) and packed struct mlsu_tile_entry_t {id, addr, tile_idx, last, mode, sew, is_load}.
- Sub-module: mlsu_predec_fifo, a generic registered FIFO parametrised by type and DEPTH with flush_i.

Test Plan:
- Row: base=0x100, ADDR_SHIFT=1, sew=2, tile=3, ready=1 -> addrs 0x200, 0x204, 0x208; idx 0,1,2; last only on the third; first valid 2 cycles after accept.
- Col: base=0x40, stride=0x80, tile=2 -> 0x80, 0x100; mode=3'b010.
- Reverse: base=0x0, stride=0x10, tile=2, ADDR_W=64 -> 0x0, 0xFFFF_FFFF_FFFF_FFF0 (wrap).
- Backpressure: predec_ready_i=0, tile=8, DEPTH=4 -> exactly 4 entries buffered; req_ready_o=0; release -> remaining 4 in order, no loss or duplication.
- Back-to-back: two requests tile=1 and tile=2 -> second accepted in the cycle of the first's enqueue; 3 entries on consecutive cycles.
- Flush at third entry of tile=5 with 2 entries queued -> next cycle valid=0, busy_o=0; a following mop=3 request -> err_o pulse and no entry.
